// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and frame constants.
package uart_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
   localparam int UART_DATA_BITS  = 8;
   localparam int UART_FRAME_BITS = 10;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; push when full and pop when empty are ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       din,
   input  logic                   pop,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;
   assign full    = count == (AW+1)'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1 serialiser with registered status outputs.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          tx_wen,
   input  logic [7:0]                    tx_data,
   input  logic                          clr_overflow,
   output logic                          tx,
   output logic                          tx_busy,
   output logic                          tx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          tx_overflow
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   uart_tx_state_t state;
   logic [CW-1:0]  baud_cnt;
   logic [2:0]     bit_idx;
   logic [7:0]     shift, dout;
   logic           full, empty, pop, bit_end;
   assign bit_end  = baud_cnt == CW'(CLKS_PER_BIT - 1);
   assign pop      = !empty && (state == IDLE || (state == STOP && bit_end));
   assign tx_ready = !full;
   sync_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_wen),
      .din   (tx_data),
      .pop   (pop),
      .dout  (dout),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );
   // tx follows the state one cycle late, so the start bit begins two edges after the push
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         baud_cnt    <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         tx          <= 1'b1;
         tx_busy     <= 1'b0;
         tx_overflow <= 1'b0;
      end else begin
         tx          <= state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
         tx_busy     <= state != IDLE || !empty;
         tx_overflow <= (tx_wen && full) || (tx_overflow && !clr_overflow);
         case (state)
            IDLE:
               if (!empty) begin
                  shift    <= dout;
                  baud_cnt <= '0;
                  state    <= START;
               end
            START:
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= DATA;
               end else baud_cnt <= baud_cnt + 1'b1;
            DATA:
               if (bit_end) begin
                  baud_cnt <= '0;
                  shift    <= shift >> 1;
                  bit_idx  <= bit_idx + 1'b1;
                  if (bit_idx == 3'(UART_DATA_BITS - 1)) state <= STOP;
               end else baud_cnt <= baud_cnt + 1'b1;
            STOP:
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (!empty) begin
                     shift <= dout;
                     state <= START;
                  end else state <= IDLE;
               end else baud_cnt <= baud_cnt + 1'b1;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of framing, queueing, overflow and reset for uart_tx.
module tb_uart_tx;
   logic       clk, rst, tx_wen, clr_overflow;
   logic [7:0] tx_data;
   logic       tx, tx_busy, tx_ready, tx_overflow;
   logic [3:0] fifo_count;
   int         checks = 0, errors = 0, cyc = 0;

   uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .tx_wen       (tx_wen),
      .tx_data      (tx_data),
      .clr_overflow (clr_overflow),
      .tx           (tx),
      .tx_busy      (tx_busy),
      .tx_ready     (tx_ready),
      .fifo_count   (fifo_count),
      .tx_overflow  (tx_overflow)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      tx_data = d;
      tx_wen  = 1;
      step();
      tx_wen  = 0;
      tx_data = 8'hXX;
   endtask

   task automatic recv(output logic [7:0] b, output int s_cyc, output logic [3:0] cnt0);
      int n = 0;
      b = 8'h00;
      while (tx !== 1'b0 && n < 200) begin
         step();
         n++;
      end
      s_cyc = cyc;
      cnt0  = fifo_count;
      checks++;
      if (tx !== 1'b0) begin
         errors++;
         $display("FAIL recv_timeout: tx=%b, required start bit 0 within 200 cycles", tx);
         return;
      end
      step();
      checks++;
      if (tx !== 1'b0) begin
         errors++;
         $display("FAIL recv_start_mid: tx=%b required 0", tx);
      end
      for (int i = 0; i < 8; i++) begin
         repeat (4) step();
         b[i] = tx;
      end
      repeat (4) step();
      checks++;
      if (tx !== 1'b1) begin
         errors++;
         $display("FAIL recv_stop: tx=%b required 1", tx);
      end
   endtask

   task automatic test_reset();
      rst = 0;
      repeat (3) step();
      checks++;
      if ({tx, tx_busy, tx_ready, fifo_count, tx_overflow} !== {1'b1, 1'b0, 1'b1, 4'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: tx=%b busy=%b ready=%b count=%0d ovf=%b required 1 0 1 0 0",
                  tx, tx_busy, tx_ready, fifo_count, tx_overflow);
      end
      rst = 1;
      for (int i = 0; i < 50; i++) begin
         step();
         checks++;
         if ({tx, tx_busy, tx_ready, fifo_count} !== {1'b1, 1'b0, 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL idle_cycle%0d: tx=%b busy=%b ready=%b count=%0d required 1 0 1 0",
                     i, tx, tx_busy, tx_ready, fifo_count);
         end
      end
   endtask

   task automatic test_single();
      logic [7:0] e = 8'hA5;
      push(e);
      step();
      checks++;
      if (tx !== 1'b1) begin
         errors++;
         $display("FAIL single_k1: tx=%b required 1", tx);
      end
      for (int j = 2; j <= 5; j++) begin
         step();
         checks++;
         if (tx !== 1'b0) begin
            errors++;
            $display("FAIL single_start_k%0d: tx=%b required 0", j, tx);
         end
      end
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 4; j++) begin
            step();
            checks++;
            if (tx !== e[i]) begin
               errors++;
               $display("FAIL single_bit%0d: tx=%b required %b", i, tx, e[i]);
            end
         end
      for (int j = 0; j < 4; j++) begin
         step();
         checks++;
         if (tx !== 1'b1) begin
            errors++;
            $display("FAIL single_stop: tx=%b required 1", tx);
         end
      end
      checks++;
      if (tx_busy !== 1'b1) begin
         errors++;
         $display("FAIL single_busy_k41: busy=%b required 1", tx_busy);
      end
      step();
      checks++;
      if (tx_busy !== 1'b0) begin
         errors++;
         $display("FAIL single_busy_k42: busy=%b required 0", tx_busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_b [3];
      logic [3:0] exp_c [3];
      logic [7:0] b;
      logic [3:0] c;
      int         s, prev;
      exp_b = '{8'h00, 8'hFF, 8'h55};
      exp_c = '{4'd2, 4'd1, 4'd0};
      push(8'h00);
      checks++;
      if (fifo_count !== 4'd1) begin
         errors++;
         $display("FAIL b2b_count_k: count=%0d required 1", fifo_count);
      end
      push(8'hFF);
      checks++;
      if (fifo_count !== 4'd1) begin
         errors++;
         $display("FAIL b2b_count_k1: count=%0d required 1", fifo_count);
      end
      push(8'h55);
      prev = 0;
      for (int f = 0; f < 3; f++) begin
         recv(b, s, c);
         checks++;
         if (b !== exp_b[f]) begin
            errors++;
            $display("FAIL b2b_byte%0d: got %h required %h", f, b, exp_b[f]);
         end
         checks++;
         if (c !== exp_c[f]) begin
            errors++;
            $display("FAIL b2b_count_frame%0d: count=%0d required %0d", f, c, exp_c[f]);
         end
         if (f > 0) begin
            checks++;
            if (s - prev != 40) begin
               errors++;
               $display("FAIL b2b_gap%0d: start spacing %0d required 40", f, s - prev);
            end
         end
         prev = s;
      end
      repeat (6) step();
      checks++;
      if (tx_busy !== 1'b0 || tx !== 1'b1) begin
         errors++;
         $display("FAIL b2b_done: busy=%b tx=%b required 0 1", tx_busy, tx);
      end
   endtask

   task automatic test_overflow();
      fork
         begin
            for (int i = 0; i < 10; i++) push(8'h10 + 8'(i));
            checks++;
            if ({tx_overflow, tx_ready, fifo_count} !== {1'b1, 1'b0, 4'd8}) begin
               errors++;
               $display("FAIL ovf_set: ovf=%b ready=%b count=%0d required 1 0 8",
                        tx_overflow, tx_ready, fifo_count);
            end
            clr_overflow = 1;
            step();
            clr_overflow = 0;
            checks++;
            if (tx_overflow !== 1'b0) begin
               errors++;
               $display("FAIL ovf_clear: ovf=%b required 0", tx_overflow);
            end
            clr_overflow = 1;
            push(8'hEE);
            clr_overflow = 0;
            checks++;
            if (tx_overflow !== 1'b1 || fifo_count !== 4'd8) begin
               errors++;
               $display("FAIL ovf_priority: ovf=%b count=%0d required 1 8", tx_overflow, fifo_count);
            end
            clr_overflow = 1;
            step();
            clr_overflow = 0;
            checks++;
            if (tx_overflow !== 1'b0) begin
               errors++;
               $display("FAIL ovf_clear2: ovf=%b required 0", tx_overflow);
            end
         end
         begin
            logic [7:0] b;
            logic [3:0] c;
            int         s;
            for (int i = 0; i < 9; i++) begin
               recv(b, s, c);
               checks++;
               if (b !== 8'h10 + 8'(i)) begin
                  errors++;
                  $display("FAIL ovf_byte%0d: got %h required %h", i, b, 8'h10 + 8'(i));
               end
            end
         end
      join
      repeat (6) step();
      checks++;
      if (tx_busy !== 1'b0 || fifo_count !== 4'd0) begin
         errors++;
         $display("FAIL ovf_done: busy=%b count=%0d required 0 0", tx_busy, fifo_count);
      end
   endtask

   task automatic test_reset_mid_frame();
      push(8'h3C);
      push(8'h11);
      push(8'h22);
      checks++;
      if (fifo_count !== 4'd2) begin
         errors++;
         $display("FAIL rmf_queued: count=%0d required 2", fifo_count);
      end
      repeat (17) step();
      checks++;
      if (tx !== 1'b1) begin
         errors++;
         $display("FAIL rmf_bit3: tx=%b required 1", tx);
      end
      rst = 0;
      step();
      checks++;
      if (tx !== 1'b1 || fifo_count !== 4'd0 || tx_busy !== 1'b0) begin
         errors++;
         $display("FAIL rmf_reset: tx=%b count=%0d busy=%b required 1 0 0", tx, fifo_count, tx_busy);
      end
      rst = 1;
      for (int i = 0; i < 100; i++) begin
         step();
         checks++;
         if (tx !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL rmf_quiet%0d: tx=%b busy=%b required 1 0", i, tx, tx_busy);
         end
      end
   endtask

   initial begin
      rst = 0;
      tx_wen = 0;
      tx_data = 8'h00;
      clr_overflow = 0;
      #1;
      test_reset();
      test_single();
      repeat (5) step();
      test_back_to_back();
      repeat (5) step();
      test_overflow();
      repeat (5) step();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
